// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and sizing helpers for the UART command responder.
//   rx_state_t / tx_state_t : FSM state encodings
//   FRAME_BYTES             : bytes per command frame (cmd, data_hi, data_lo)
//   cnt_w()                 : counter width able to hold values 0..n-1
package uart_cmd_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_t;

  localparam int FRAME_BYTES = 3;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: 8N1 serialiser for the 1-byte response.
//   clk, rst   : clock, async active-high reset
//   send_resp  : 1-cycle request; accepted only while idle
//   resp       : byte sampled on the accepted send_resp cycle
//   TX         : serial output, idle high
//   tx_busy    : transmission in progress
//   resp_sent  : last response finished; held until the next accepted request
module uart_resp_tx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_resp,
  input  logic [7:0] resp,
  output logic       TX,
  output logic       tx_busy,
  output logic       resp_sent
);

  localparam int             BW        = cnt_w(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);

  tx_state_t       state;
  logic [9:0]      sh;
  logic [BW-1:0]   cnt;
  logic [3:0]      bit_cnt;

  // The line is always the shift register LSB; ones are shifted in behind the
  // frame so the register idles at all-ones and TX comes straight off a flop.
  assign TX = sh[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      sh        <= '1;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (send_resp) begin
            sh        <= {1'b1, resp, 1'b0};
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_busy   <= 1'b1;
            resp_sent <= 1'b0;
            state     <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (cnt == BAUD_LAST) begin
            cnt <= '0;
            if (bit_cnt == 4'd9) begin
              sh        <= '1;
              tx_busy   <= 1'b0;
              resp_sent <= 1'b1;
              state     <= TX_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              sh      <= {1'b1, sh[9:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: receives 3-byte command frames (cmd, data_hi, data_lo)
// over 8N1 serial and transmits a 1-byte response on request.
//   clk, rst     : clock, async active-high reset
//   RX           : serial input (asynchronous)
//   clr_cmd_rdy  : consumer acknowledge; clears cmd_rdy and frm_err
//   send_resp    : 1-cycle request to transmit resp
//   resp         : response byte
//   TX           : serial output
//   cmd, data    : last complete frame
//   cmd_rdy      : complete frame available
//   resp_sent    : response finished
//   tx_busy      : response transmission in progress
//   frm_err      : sticky stop-bit error
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int             BW        = cnt_w(BAUD_DIV);
  localparam int             GW        = cnt_w(GAP_BITS * BAUD_DIV + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]  HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_BITS * BAUD_DIV - 1);

  logic             rx_s1, rx_s2, rx_d, fall;
  rx_state_t        rx_state;
  logic [BW-1:0]    baud_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       rx_sh;
  logic [IDX_W-1:0] idx;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       hold_cmd, hold_hi, hold_lo;
  logic             frame_done;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  // Statement order matters: clears come first, sets later so a same-cycle
  // set wins through non-blocking last-assignment semantics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      hold_cmd   <= '0;
      hold_hi    <= '0;
      hold_lo    <= '0;
      frame_done <= 1'b0;
      cmd        <= '0;
      data       <= '0;
      cmd_rdy    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
        frm_err <= 1'b0;
      end

      // Inter-byte gap: a partial frame that stalls too long is dropped.
      if (rx_state == RX_IDLE && idx != '0) begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt <= '0;
          idx     <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end else begin
        gap_cnt <= '0;
      end

      case (rx_state)
        RX_IDLE: begin
          if (fall) begin
            baud_cnt <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (!rx_s2) begin
              rx_state <= RX_DATA;
              if (idx == '0) cmd_rdy <= 1'b0;
            end else begin
              rx_state <= RX_IDLE;      // glitch shorter than half a bit
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            rx_sh    <= {rx_s2, rx_sh[7:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              if (idx == '0)                hold_cmd <= rx_sh;
              else if (idx == IDX_W'(1))    hold_hi  <= rx_sh;
              else                          hold_lo  <= rx_sh;
              if (idx == IDX_W'(FRAME_BYTES - 1)) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              frm_err <= 1'b1;
              idx     <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase

      // Outputs update only on a complete frame, one cycle after the last
      // stop sample so the data_lo holding register is already loaded.
      if (frame_done) begin
        cmd     <= hold_cmd;
        data    <= {hold_hi, hold_lo};
        cmd_rdy <= 1'b1;
      end
    end
  end

  uart_resp_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .send_resp (send_resp),
    .resp      (resp),
    .TX        (TX),
    .tx_busy   (tx_busy),
    .resp_sent (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder (BAUD_DIV=16, GAP_BITS=4).
// Expected frames / TX bit patterns are queued at stimulus time; two monitors
// pop and compare when the DUT presents a frame or starts a TX byte.
module tb_uart_cmd_responder;

  localparam int BD = 16;
  localparam int GB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy, resp_sent, tx_busy, frm_err;

  uart_cmd_responder #(.BAUD_DIV(BD), .GAP_BITS(GB)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [23:0] frm_q[$];
  logic [9:0]  tx_q[$];
  bit          tx_mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b000, TX, cmd, data, cmd_rdy, resp_sent, tx_busy, frm_err};
  endfunction

  // Called at a negedge; drives one 8N1 byte, leaves the line high.
  task automatic rx_byte(input logic [7:0] b, input logic stop = 1'b1);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] r, input logic [9:0] exp);
    if (tx_mon_en) tx_q.push_back(exp);
    resp      = r;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  // Frame monitor: a new frame is a cmd_rdy rise or new cmd/data while ready.
  initial begin : frame_mon
    logic [23:0] prev_v, e;
    logic        prev_rdy;
    prev_v = '0; prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = '0; prev_rdy = 1'b0;
      end else begin
        if (cmd_rdy && (!prev_rdy || {cmd, data} != prev_v)) begin
          if (frm_q.size() == 0) chk("unexpected_frame", {8'h00, cmd, data}, 32'h0100_0000);
          else begin
            e = frm_q.pop_front();
            chk("frame", {8'h00, cmd, data}, {8'h00, e});
          end
        end
        prev_rdy = cmd_rdy;
        prev_v   = {cmd, data};
      end
    end
  end

  // TX monitor: on a start edge, sample all 10 bits at their centres.
  initial begin : tx_mon
    logic [9:0] got;
    logic       tp;
    tp = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx_mon_en && tp && !TX) begin
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) repeat (BD) @(negedge clk);
          got[i] = TX;
        end
        if (tx_q.size() == 0) chk("unexpected_tx", {22'h0, got}, 32'h0000_0400);
        else chk("tx_bits", {22'h0, got}, {22'h0, tx_q.pop_front()});
      end
      tp = TX;
    end
  end

  initial begin : stim
    int c;
    bit busy_ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", outs(), 32'h1000_0000);
    rst = 1'b0;
    idle(20);

    // Frame ordering
    frm_q.push_back(24'h05A53C);
    rx_byte(8'h05);
    chk("rdy_after_byte0", {31'h0, cmd_rdy}, 32'h0);
    rx_byte(8'hA5);
    rx_byte(8'h3C);
    chk("f1_cmd", {24'h0, cmd}, 32'h05);
    chk("f1_data", {16'h0, data}, 32'hA53C);
    chk("f1_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("f1_frm_err", {31'h0, frm_err}, 32'h0);
    idle(4);
    pulse_clr();
    chk("clr_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("clr_hold", {8'h00, cmd, data}, 32'h0005_A53C);

    // Glitch shorter than half a bit
    RX = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_state", {6'h0, cmd_rdy, frm_err, cmd, data}, 32'h0005_A53C);

    // Stop-bit error drops the partial frame
    rx_byte(8'h55);
    rx_byte(8'h66, 1'b0);
    idle(8);
    chk("stop_err_set", {31'h0, frm_err}, 32'h1);
    chk("stop_err_rdy", {31'h0, cmd_rdy}, 32'h0);
    frm_q.push_back(24'h112233);
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    chk("f2_cmd_data", {8'h00, cmd, data}, 32'h0011_2233);
    chk("frm_err_sticky", {31'h0, frm_err}, 32'h1);
    pulse_clr();
    chk("frm_err_clr", {30'h0, frm_err, cmd_rdy}, 32'h0);

    // Gap timeout
    frm_q.push_back(24'h010203);
    rx_byte(8'h07); rx_byte(8'h08);
    idle(5 * BD);
    rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03);
    chk("gap_cmd_data", {8'h00, cmd, data}, 32'h0001_0203);

    // Response transmit 0xC3 with an ignored second request at clock 50
    idle(4);
    send_tx(8'hC3, 10'b1_1100_0011_0);
    chk("tx_busy_start", {31'h0, tx_busy}, 32'h1);
    c = 0; busy_ok = 1'b1;
    while (!resp_sent && c < 400) begin
      @(negedge clk);
      c++;
      if (c == 50) begin resp = 8'hFF; send_resp = 1'b1; end
      else if (c == 51) send_resp = 1'b0;
      if (!resp_sent && !tx_busy) busy_ok = 1'b0;
    end
    chk("resp_latency", c, 32'd160);
    chk("busy_held", {31'h0, busy_ok}, 32'h1);
    chk("tx_done_busy", {31'h0, tx_busy}, 32'h0);
    idle(20);
    chk("resp_sent_hold", {30'h0, resp_sent, TX}, 32'h3);

    // Full duplex plus back-to-back frames without clearing
    frm_q.push_back(24'h090001);
    frm_q.push_back(24'h0AFFFE);
    send_tx(8'h5A, 10'b1_0101_1010_0);
    rx_byte(8'h09); rx_byte(8'h00); rx_byte(8'h01);
    rx_byte(8'h0A); rx_byte(8'hFF); rx_byte(8'hFE);
    chk("dup_result", {7'h0, cmd_rdy, cmd, data}, 32'h010A_FFFE);
    idle(20);

    // Reset mid-frame and mid-TX
    tx_mon_en = 1'b0;
    rx_byte(8'h44); rx_byte(8'h55);
    send_tx(8'h77, 10'h0);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD + 5) @(negedge clk);
    chk("pre_reset_busy", {31'h0, tx_busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_reset_state", outs(), 32'h1000_0000);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    tx_mon_en = 1'b1;
    frm_q.push_back(24'h010000);
    rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'h00);
    chk("post_reset_rdy_cmd", {23'h0, cmd_rdy, cmd}, 32'h101);

    idle(20);
    chk("frames_pending", frm_q.size(), 32'd0);
    chk("tx_pending", tx_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
